// File: rtl/ents_bank_scheduler.sv
// ---------------------------------------------------------------------------
// ents_bank_scheduler
//
// Double-buffered entity bank scheduler. The game logic announces a new
// object map (logic_done); the scheduler starts the entity drawer, steers
// its writes into the back bank, and swaps front/back on the next vertical
// blank after the drawer has finished.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   logic_done            pulse: new object map ready
//   vblank_start          pulse: renderer entered vertical blanking
//   draw_done, ent_count  pulse + entity count from the drawer
//   wr_en/wr_addr/wr_data drawer write port
//   draw_start            pulse to the drawer (its new_state input)
//   next_screen           pulse to the drawer on bank swap
//   we0/we1               bank write enables (back bank only, DRAW only)
//   bank_addr/bank_data   shared write address/data to both banks
//   front_bank            bank the renderer reads
//   render_count          entity count of the front bank
//   frame_cnt             completed swaps, wraps
//   busy                  scheduler not idle
//
// Optional feature (macro ENTS_DROP_CNT_EN):
//   dropped_frames        saturating count of vblanks missed while drawing
//                         and logic_done pulses dropped while one is pending
// ---------------------------------------------------------------------------
module ents_bank_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        logic_done,
    input  logic        vblank_start,
    input  logic        draw_done,
    input  logic [7:0]  ent_count,
    input  logic        wr_en,
    input  logic [7:0]  wr_addr,
    input  logic [20:0] wr_data,
    output logic        draw_start,
    output logic        next_screen,
    output logic        we0,
    output logic        we1,
    output logic [7:0]  bank_addr,
    output logic [20:0] bank_data,
    output logic        front_bank,
    output logic [7:0]  render_count,
    output logic [15:0] frame_cnt,
    output logic        busy
`ifdef ENTS_DROP_CNT_EN
    ,
    output logic [7:0]  dropped_frames
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DRAW      = 2'd1,
        ST_WAIT_SWAP = 2'd2,
        ST_SWAP      = 2'd3
    } state_t;

    state_t      state_q;
    logic        pending_q;
    logic        front_bank_q;
    logic [7:0]  render_count_q;
    logic [7:0]  count_hold_q;
    logic [15:0] frame_cnt_q;
    logic        draw_start_q;
    logic        next_screen_q;

    // Writes only ever target the back bank, and only while drawing.
    logic draw_wr;
    assign draw_wr = wr_en && (state_q == ST_DRAW);

    assign we0          = draw_wr && (front_bank_q == 1'b1);
    assign we1          = draw_wr && (front_bank_q == 1'b0);
    assign bank_addr    = wr_addr;
    assign bank_data    = wr_data;
    assign front_bank   = front_bank_q;
    assign render_count = render_count_q;
    assign frame_cnt    = frame_cnt_q;
    assign draw_start   = draw_start_q;
    assign next_screen  = next_screen_q;
    assign busy         = (state_q != ST_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            pending_q      <= 1'b0;
            front_bank_q   <= 1'b0;
            render_count_q <= 8'd0;
            count_hold_q   <= 8'd0;
            frame_cnt_q    <= 16'd0;
            draw_start_q   <= 1'b0;
            next_screen_q  <= 1'b0;
        end else begin
            draw_start_q  <= 1'b0;
            next_screen_q <= 1'b0;

            // One-deep request memory while a frame is in flight.
            if (state_q != ST_IDLE && logic_done)
                pending_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (logic_done || pending_q) begin
                        draw_start_q <= 1'b1;
                        pending_q    <= 1'b0;
                        state_q      <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    // A vblank coinciding with draw_done is too early to swap.
                    if (draw_done) begin
                        count_hold_q <= ent_count;
                        state_q      <= ST_WAIT_SWAP;
                    end
                end
                ST_WAIT_SWAP: begin
                    // Swap side effects land together with the next_screen
                    // pulse, one cycle after vblank_start.
                    if (vblank_start) begin
                        front_bank_q   <= ~front_bank_q;
                        render_count_q <= count_hold_q;
                        frame_cnt_q    <= frame_cnt_q + 16'd1;
                        next_screen_q  <= 1'b1;
                        state_q        <= ST_SWAP;
                    end
                end
                ST_SWAP: begin
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef ENTS_DROP_CNT_EN
    logic [7:0] dropped_q;
    logic [7:0] dropped_d;
    logic [1:0] drop_inc;
    logic [8:0] drop_sum;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        drop_inc  = 2'd0;
        if (vblank_start && state_q == ST_DRAW)
            drop_inc = drop_inc + 2'd1;
        if (logic_done && state_q != ST_IDLE && pending_q)
            drop_inc = drop_inc + 2'd1;
        drop_sum  = {1'b0, dropped_q} + {7'd0, drop_inc};
        dropped_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dropped_q <= 8'd0;
        else
            dropped_q <= dropped_d;
    end

    assign dropped_frames = dropped_q;
`endif

endmodule

// File: tb/tb_ents_bank_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ents_bank_scheduler
//
// Directed bench for ents_bank_scheduler. Inputs change 1 time unit after a
// rising edge; outputs are sampled at that same point, well away from the
// next active edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ents_bank_scheduler;

    logic        clk;
    logic        rst_n;
    logic        logic_done;
    logic        vblank_start;
    logic        draw_done;
    logic [7:0]  ent_count;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [20:0] wr_data;
    logic        draw_start;
    logic        next_screen;
    logic        we0;
    logic        we1;
    logic [7:0]  bank_addr;
    logic [20:0] bank_data;
    logic        front_bank;
    logic [7:0]  render_count;
    logic [15:0] frame_cnt;
    logic        busy;
`ifdef ENTS_DROP_CNT_EN
    logic [7:0]  dropped_frames;
`endif

    int checks = 0;
    int errors = 0;

    ents_bank_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .logic_done   (logic_done),
        .vblank_start (vblank_start),
        .draw_done    (draw_done),
        .ent_count    (ent_count),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .draw_start   (draw_start),
        .next_screen  (next_screen),
        .we0          (we0),
        .we1          (we1),
        .bank_addr    (bank_addr),
        .bank_data    (bank_data),
        .front_bank   (front_bank),
        .render_count (render_count),
        .frame_cnt    (frame_cnt),
        .busy         (busy)
`ifdef ENTS_DROP_CNT_EN
        ,
        .dropped_frames (dropped_frames)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle pulse on the chosen input; afterwards the edge that
    // sampled it has passed and outputs reflect it.
    task automatic pulse_ld();
        logic_done = 1'b1; tick(); logic_done = 1'b0;
    endtask

    task automatic pulse_vb();
        vblank_start = 1'b1; tick(); vblank_start = 1'b0;
    endtask

    task automatic pulse_dd(input logic [7:0] cnt);
        draw_done = 1'b1; ent_count = cnt; tick(); draw_done = 1'b0; ent_count = 8'd0;
    endtask

    initial begin
        rst_n = 1'b0; logic_done = 1'b0; vblank_start = 1'b0; draw_done = 1'b0;
        ent_count = 8'd0; wr_en = 1'b1; wr_addr = 8'd3; wr_data = 21'd7;

        // ---- reset state ----
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_draw_start", draw_start, 0);
        check("rst_next_screen", next_screen, 0);
        check("rst_front", front_bank, 0);
        check("rst_render", render_count, 0);
        check("rst_frame", frame_cnt, 0);
        check("rst_we", {we1, we0}, 0);
        wr_en = 1'b0;

        // ---- first frame: start, write to bank 1, swap ----
        rst_n = 1'b1;
        repeat (10) tick();
        pulse_ld();
        check("start_draw_start", draw_start, 1);
        check("start_busy", busy, 1);
        wr_en = 1'b1; wr_addr = 8'd5; wr_data = 21'h1ABCD; #1;
        check("draw_we1", we1, 1);
        check("draw_we0", we0, 0);
        check("draw_addr", bank_addr, 5);
        check("draw_data", bank_data, 32'h1ABCD);
        tick();
        check("start_pulse_once", draw_start, 0);
        wr_en = 1'b0;

        pulse_dd(8'd42);
        check("wait_busy", busy, 1);
        check("wait_render_unchanged", render_count, 0);
        wr_en = 1'b1; #1;
        check("wait_we_blocked", {we1, we0}, 0);
        wr_en = 1'b0;
        for (int i = 0; i < 19; i++) begin
            tick();
            check("wait_no_swap", next_screen, 0);
        end
        pulse_vb();
        check("swap_next_screen", next_screen, 1);
        check("swap_front", front_bank, 1);
        check("swap_render", render_count, 42);
        check("swap_frame", frame_cnt, 1);
        tick();
        check("swap_pulse_once", next_screen, 0);
        check("idle_busy", busy, 0);
        wr_en = 1'b1; #1;
        check("idle_we_blocked", {we1, we0}, 0);
        wr_en = 1'b0;

        // ---- pending request during DRAW, second one dropped ----
        pulse_ld();
        check("f2_draw_start", draw_start, 1);
        wr_en = 1'b1; #1;
        check("f2_we0", we0, 1);
        check("f2_we1", we1, 0);
        wr_en = 1'b0;
        pulse_ld();
        pulse_ld();
        pulse_dd(8'd7);
        pulse_vb();
        check("f2_next_screen", next_screen, 1);
        check("f2_front", front_bank, 0);
        check("f2_render", render_count, 7);
        check("f2_frame", frame_cnt, 2);
        tick();
        check("f2_idle", busy, 0);
        check("f2_no_start_yet", draw_start, 0);
        tick();
        check("pend_draw_start", draw_start, 1);
        check("pend_busy", busy, 1);
`ifdef ENTS_DROP_CNT_EN
        check("pend_dropped", dropped_frames, 1);
`endif
        pulse_dd(8'd11);
        pulse_vb();
        check("f3_frame", frame_cnt, 3);
        check("f3_front", front_bank, 1);
        tick();
        tick();
        check("f3_no_second_pending", draw_start, 0);
        check("f3_idle", busy, 0);

        // ---- draw_done and vblank_start together: no swap ----
        pulse_ld();
        draw_done = 1'b1; ent_count = 8'd9; vblank_start = 1'b1;
        tick();
        draw_done = 1'b0; ent_count = 8'd0; vblank_start = 1'b0;
        check("coinc_next_screen", next_screen, 0);
        check("coinc_busy", busy, 1);
        repeat (3) tick();
        check("coinc_frame_hold", frame_cnt, 3);
        check("coinc_front_hold", front_bank, 1);
        pulse_vb();
        check("coinc_swap", next_screen, 1);
        check("coinc_front", front_bank, 0);
        check("coinc_render", render_count, 9);
        check("coinc_frame", frame_cnt, 4);
`ifdef ENTS_DROP_CNT_EN
        check("coinc_dropped", dropped_frames, 2);
`endif
        tick();

        // ---- reset mid-DRAW ----
        pulse_ld();   // front_bank is 0 again here, so make it 1 first
        pulse_dd(8'd3);
        pulse_vb();
        tick();
        check("pre_rst_front", front_bank, 1);
        pulse_ld();
        tick();
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0; #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_front", front_bank, 0);
        check("mid_rst_frame", frame_cnt, 0);
        check("mid_rst_render", render_count, 0);
        check("mid_rst_pulses", {draw_start, next_screen}, 0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("post_rst_idle", busy, 0);
        pulse_ld();
        check("post_rst_start", draw_start, 1);
        check("post_rst_front", front_bank, 0);
        wr_en = 1'b1; wr_addr = 8'd9; #1;
        check("post_rst_we1", {we1, we0}, 2);
        wr_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
